// File: rtl/addsub_lanes_pipe.sv
// addsub_lanes_pipe: multi-lane pipelined add/subtract engine.
// Pops one operand pair per cycle from a show-ahead FIFO, computes LANES
// independent results and holds them in a credit-protected output queue.
// Optional feature macro: ADDSUB_SATURATE_EN (signed saturating lanes,
// carry reports signed overflow, one extra pipeline register).
module addsub_lanes_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter int OUT_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_avail,
    output logic                          in_rd_en,
    input  logic [LANES*DATA_WIDTH-1:0]   op1,
    input  logic [LANES*DATA_WIDTH-1:0]   op2,
    input  logic                          mode,
    output logic [LANES*DATA_WIDTH-1:0]   result,
    output logic [LANES-1:0]              carry,
    output logic                          complete,
    input  logic                          out_rd_en
);

`ifdef ADDSUB_SATURATE_EN
    localparam int SAT_STAGE = 1;
`else
    localparam int SAT_STAGE = 0;
`endif
    // The queue write itself is the last of the PIPE_STAGES registers.
    localparam int NSTG = PIPE_STAGES - 1 + SAT_STAGE;
    localparam int VW   = (NSTG > 0) ? NSTG : 1;
    localparam int BW   = LANES * DATA_WIDTH;
    localparam int PW   = $clog2(OUT_DEPTH);
    localparam int CW   = $clog2(OUT_DEPTH + 1);
    localparam int OW   = CW + 1;

    logic              accept;
    logic              pop;
    logic [BW-1:0]     in_res;
    logic [LANES-1:0]  in_cry;
    logic              wr_vld;
    logic [BW-1:0]     wr_raw;
    logic [LANES-1:0]  wr_cry;
    logic [BW-1:0]     wr_res;
    logic [VW-1:0]     pipe_vld;
    logic [OW-1:0]     occ;

    logic [BW-1:0]     mem_res [OUT_DEPTH];
    logic [LANES-1:0]  mem_cry [OUT_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [BW-1:0]     hold_res_q;
    logic [LANES-1:0]  hold_cry_q;

`ifdef ADDSUB_SATURATE_EN
    logic [DATA_WIDTH-1:0] lane_a, lane_b, lane_r;
`else
    logic [DATA_WIDTH-1:0] lane_a, lane_b;
    logic [DATA_WIDTH:0]   lane_ext;
`endif

    // Per-lane arithmetic on the operands being popped this cycle.
    always_comb begin
        in_res = '0;
        in_cry = '0;
        lane_a = '0;
        lane_b = '0;
`ifdef ADDSUB_SATURATE_EN
        lane_r = '0;
`else
        lane_ext = '0;
`endif
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_a = op1[i*DATA_WIDTH +: DATA_WIDTH];
            lane_b = op2[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef ADDSUB_SATURATE_EN
            lane_r = mode ? (lane_a + lane_b) : (lane_a - lane_b);
            in_res[i*DATA_WIDTH +: DATA_WIDTH] = lane_r;
            if (mode)
                in_cry[i] = (lane_a[DATA_WIDTH-1] == lane_b[DATA_WIDTH-1]) &&
                            (lane_r[DATA_WIDTH-1] != lane_a[DATA_WIDTH-1]);
            else
                in_cry[i] = (lane_a[DATA_WIDTH-1] != lane_b[DATA_WIDTH-1]) &&
                            (lane_r[DATA_WIDTH-1] != lane_a[DATA_WIDTH-1]);
`else
            lane_ext = mode ? ({1'b0, lane_a} + {1'b0, lane_b})
                            : ({1'b0, lane_a} - {1'b0, lane_b});
            in_res[i*DATA_WIDTH +: DATA_WIDTH] = lane_ext[DATA_WIDTH-1:0];
            in_cry[i] = lane_ext[DATA_WIDTH];
`endif
        end
    end

    generate
        if (NSTG == 0) begin : g_nopipe
            assign wr_vld   = accept;
            assign wr_raw   = in_res;
            assign wr_cry   = in_cry;
            assign pipe_vld = '0;
        end else begin : g_pipe
            logic [NSTG-1:0]  vld_q;
            logic [BW-1:0]    res_q [NSTG];
            logic [LANES-1:0] cry_q [NSTG];

            // Valid bits shift with the data; only they need clearing on reset.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= accept;
                    for (int unsigned s = 1; s < NSTG; s++)
                        vld_q[s] <= vld_q[s-1];
                end
            end

            // Free-running data shift; never stalls because credits reserve a slot.
            always_ff @(posedge clock) begin
                res_q[0] <= in_res;
                cry_q[0] <= in_cry;
                for (int unsigned s = 1; s < NSTG; s++) begin
                    res_q[s] <= res_q[s-1];
                    cry_q[s] <= cry_q[s-1];
                end
            end

            assign wr_vld   = vld_q[NSTG-1];
            assign wr_raw   = res_q[NSTG-1];
            assign wr_cry   = cry_q[NSTG-1];
            assign pipe_vld = vld_q;
        end
    endgenerate

    // Final result into the queue; saturating build clamps overflowed lanes.
    // The clamp direction is recovered from the wrapped sign bit.
    always_comb begin
        wr_res = wr_raw;
`ifdef ADDSUB_SATURATE_EN
        for (int unsigned i = 0; i < LANES; i++) begin
            if (wr_cry[i])
                wr_res[i*DATA_WIDTH +: DATA_WIDTH] =
                    wr_raw[i*DATA_WIDTH + DATA_WIDTH - 1]
                        ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                        : {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
`endif
    end

    // Credit decision: in-flight plus queued entries, less a same-cycle pop.
    always_comb begin
        occ = OW'(count_q);
        for (int unsigned s = 0; s < VW; s++)
            occ = occ + OW'(pipe_vld[s]);
        complete = (count_q != '0);
        pop      = out_rd_en & complete;
        in_rd_en = in_avail & reset & ((occ - OW'(pop)) < OW'(OUT_DEPTH));
        accept   = in_rd_en;
    end

    // Next-state for the circular queue pointers and occupancy count.
    always_comb begin
        wr_ptr_d = wr_vld ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop    ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = count_q + CW'(wr_vld) - CW'(pop);
    end

    // Queue control state; the hold registers keep the last popped head.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_res_q <= '0;
            hold_cry_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (pop) begin
                hold_res_q <= mem_res[rd_ptr_q];
                hold_cry_q <= mem_cry[rd_ptr_q];
            end
        end
    end

    // Queue storage write.
    always_ff @(posedge clock) begin
        if (wr_vld) begin
            mem_res[wr_ptr_q] <= wr_res;
            mem_cry[wr_ptr_q] <= wr_cry;
        end
    end

    assign result = complete ? mem_res[rd_ptr_q] : hold_res_q;
    assign carry  = complete ? mem_cry[rd_ptr_q] : hold_cry_q;

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(wr_vld && !pop && (count_q == CW'(OUT_DEPTH))));

endmodule

// File: tb/tb_addsub_lanes_pipe.sv
// Testbench for addsub_lanes_pipe: directed literal cases plus randomized
// traffic checked every cycle against a transaction-level queue model.
module tb_addsub_lanes_pipe;
    localparam int DW    = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int BW    = DW * LANES;
`ifdef ADDSUB_SATURATE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clock;
    logic             reset;
    logic             in_avail;
    logic             in_rd_en;
    logic [BW-1:0]    op1, op2;
    logic             mode;
    logic [BW-1:0]    result;
    logic [LANES-1:0] carry;
    logic             complete;
    logic             out_rd_en;

    addsub_lanes_pipe #(
        .DATA_WIDTH (DW),
        .LANES      (LANES),
        .PIPE_STAGES(2),
        .OUT_DEPTH  (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_avail (in_avail),
        .in_rd_en (in_rd_en),
        .op1      (op1),
        .op2      (op2),
        .mode     (mode),
        .result   (result),
        .carry    (carry),
        .complete (complete),
        .out_rd_en(out_rd_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the lane rules.
    function automatic void calc(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic m,
                                 output logic [BW-1:0] r, output logic [LANES-1:0] c);
        logic [31:0]     x, y;
        longint          sx, sy, ss;
        longint unsigned us;
        r = '0;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            x = a[i*DW +: DW];
            y = b[i*DW +: DW];
`ifdef ADDSUB_SATURATE_EN
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            ss = m ? sx + sy : sx - sy;
            us = 0;
            if (ss > 64'sd2147483647) begin
                r[i*DW +: DW] = 32'h7FFFFFFF; c[i] = 1'b1;
            end else if (ss < -64'sd2147483648) begin
                r[i*DW +: DW] = 32'h80000000; c[i] = 1'b1;
            end else begin
                r[i*DW +: DW] = ss[31:0];
            end
`else
            sx = 0; sy = 0; ss = 0;
            if (m) begin
                us = longint'(x) + longint'(y);
                r[i*DW +: DW] = us[31:0];
                c[i] = (us > 64'hFFFFFFFF);
            end else begin
                us = 0;
                r[i*DW +: DW] = x - y;
                c[i] = (x < y);
            end
`endif
        end
    endfunction

    function automatic logic [31:0] rword();
        case ($urandom_range(0, 5))
            0:       rword = 32'h0;
            1:       rword = 32'hFFFFFFFF;
            2:       rword = 32'h7FFFFFFF;
            3:       rword = 32'h80000000;
            4:       rword = 32'h1;
            default: rword = $urandom;
        endcase
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < LANES; i++) begin
            op1[i*DW +: DW] = rword();
            op2[i*DW +: DW] = rword();
        end
        mode = 1'($urandom_range(0, 1));
    endtask

    // Transaction model: every accepted pair in order, tagged with its accept cycle.
    typedef struct packed {
        int               acc;
        logic [BW-1:0]    res;
        logic [LANES-1:0] cry;
    } ent_t;

    ent_t             mq[$];
    logic [BW-1:0]    last_res;
    logic [LANES-1:0] last_cry;
    int               cyc = 0;
    bit               armed = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Per-cycle comparison at mid-cycle, then advance the model to the next edge.
    always @(negedge clock) begin
        bit               head_ok, pop_m, exp_rd;
        int               occ;
        ent_t             e;
        if (!reset) begin
            check("rd_en_in_reset", {127'b0, in_rd_en}, '0);
            mq.delete();
            last_res = '0;
            last_cry = '0;
            armed    = 1;
        end else if (armed) begin
            head_ok = (mq.size() > 0) && (mq[0].acc + LAT <= cyc);
            pop_m   = out_rd_en && head_ok;
            occ     = mq.size() - (pop_m ? 1 : 0);
            exp_rd  = in_avail && (occ < DEPTH);
            check("complete", {127'b0, complete}, {127'b0, head_ok});
            check("in_rd_en", {127'b0, in_rd_en}, {127'b0, exp_rd});
            if (head_ok) begin
                check("result", result, mq[0].res);
                check("carry", {124'b0, carry}, {124'b0, mq[0].cry});
            end else begin
                check("result_hold", result, last_res);
                check("carry_hold", {124'b0, carry}, {124'b0, last_cry});
            end
            if (pop_m) begin
                last_res = mq[0].res;
                last_cry = mq[0].cry;
                void'(mq.pop_front());
            end
            if (exp_rd) begin
                e.acc = cyc;
                calc(op1, op2, mode, e.res, e.cry);
                mq.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single transaction into an empty engine; pins latency and literal values.
    task automatic one_shot(input string nm, input logic [BW-1:0] a, input logic [BW-1:0] b,
                            input logic m, input logic [BW-1:0] er, input logic [LANES-1:0] ec);
        op1 = a; op2 = b; mode = m; in_avail = 1'b1; out_rd_en = 1'b0;
        #1;
        check({nm, "_accept"}, {127'b0, in_rd_en}, {127'b0, 1'b1});
        tick();
        in_avail = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            check({nm, "_early"}, {127'b0, complete}, '0);
            tick();
        end
        check({nm, "_complete"}, {127'b0, complete}, {127'b0, 1'b1});
        check({nm, "_result"}, result, er);
        check({nm, "_carry"}, {124'b0, carry}, {124'b0, ec});
        out_rd_en = 1'b1;
        tick();
        out_rd_en = 1'b0;
    endtask

    initial begin
        int nacc, nres, first, last;
        reset = 1'b0; in_avail = 1'b0; out_rd_en = 1'b0; mode = 1'b0;
        op1 = '0; op2 = '0;
        repeat (3) tick();
        check("rst_complete", {127'b0, complete}, '0);
        check("rst_result", result, '0);
        check("rst_carry", {124'b0, carry}, '0);
        reset = 1'b1;
        tick();

`ifdef ADDSUB_SATURATE_EN
        one_shot("sat_add", {4{32'h7FFFFFFF}}, {4{32'h1}}, 1'b1, {4{32'h7FFFFFFF}}, 4'hF);
        one_shot("sat_sub", {4{32'h80000000}}, {4{32'h1}}, 1'b0, {4{32'h80000000}}, 4'hF);
        one_shot("sat_plain", {4{32'd10}}, {4{32'd3}}, 1'b0, {4{32'd7}}, 4'h0);
`else
        one_shot("sub_10_3", BW'(10), BW'(3), 1'b0, BW'(7), 4'h0);
        one_shot("sub_borrow", '0, {4{32'h1}}, 1'b0, {4{32'hFFFFFFFF}}, 4'hF);
        one_shot("add_carry", {4{32'hFFFFFFFF}}, {4{32'h2}}, 1'b1, {4{32'h1}}, 4'hF);
`endif

        // Backpressure: only DEPTH credits available with the consumer stalled.
        out_rd_en = 1'b0;
        in_avail  = 1'b1;
        nacc = 0;
        for (int t = 0; t < 6; t++) begin
            rand_ops();
            #1;
            if (in_rd_en) nacc++;
            tick();
        end
        check("bp_accepted", BW'(nacc), BW'(4));
        check("bp_blocked", {127'b0, in_rd_en}, '0);
        out_rd_en = 1'b1;
        #1;
        check("bp_credit_same_cycle", {127'b0, in_rd_en}, {127'b0, 1'b1});
        tick();
        in_avail = 1'b0;
        repeat (10) tick();

        // Streaming: 20 accepts must give 20 back-to-back results.
        out_rd_en = 1'b1;
        nres = 0; first = -1; last = -1;
        for (int t = 0; t < 30; t++) begin
            in_avail = (t < 20);
            rand_ops();
            #1;
            if (complete) begin
                if (first < 0) first = t;
                last = t;
                nres++;
            end
            tick();
        end
        check("stream_count", BW'(nres), BW'(20));
        check("stream_no_gaps", BW'(last - first), BW'(19));

        // Mid-operation reset flushes queued entries.
        out_rd_en = 1'b0;
        in_avail  = 1'b1;
        repeat (3) begin rand_ops(); tick(); end
        in_avail = 1'b0;
        repeat (LAT + 2) tick();
        check("flush_pre_complete", {127'b0, complete}, {127'b0, 1'b1});
        in_avail = 1'b1;
        reset    = 1'b0;
        #1;
        check("flush_rd_en_low", {127'b0, in_rd_en}, '0);
        tick();
        check("flush_complete", {127'b0, complete}, '0);
        reset = 1'b1; in_avail = 1'b0; out_rd_en = 1'b1;
        repeat (3) tick();
        check("flush_no_stale_complete", {127'b0, complete}, '0);
        check("flush_no_stale_result", result, '0);

        // Randomized traffic with varying pressure and one reset.
        for (int t = 0; t < 400; t++) begin
            rand_ops();
            in_avail  = ($urandom_range(0, 3) != 0);
            out_rd_en = (t < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            reset     = (t != 250);
            tick();
        end
        reset = 1'b1; in_avail = 1'b0; out_rd_en = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
